// File: rtl/uart_rx_frontend.sv
// 8N1 UART receive front end: rx synchroniser, 16x oversampling deframer with
// 3-sample majority vote, and a small byte FIFO with a valid/ready output.
// Optional even-parity support is enabled by defining UART_RX_PARITY_EN.
module uart_rx_frontend #(
  parameter int CLK_FREQ   = 100_000_000,
  parameter int BAUD       = 115_200,
  parameter int FIFO_DEPTH = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx,
  output logic [7:0] m_data,
  output logic       m_valid,
  input  logic       m_ready,
  output logic       frame_err,
  output logic       overrun,
  output logic       busy
`ifdef UART_RX_PARITY_EN
  , output logic     parity_err
`endif
);

  localparam int TICK_DIV = CLK_FREQ / (BAUD * 16);
  localparam int TICK_W   = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int AW       = $clog2(FIFO_DEPTH);
  localparam logic [TICK_W-1:0] TICK_MAX = TICK_W'(TICK_DIV - 1);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
`ifdef UART_RX_PARITY_EN
    ST_PARITY,
`endif
    ST_STOP,
    ST_WAIT_IDLE
  } state_t;

  state_t            state;
  logic [1:0]        sync_q;
  logic              rx_s;
  logic              rx_d;
  logic [TICK_W-1:0] tick_cnt;
  logic              tick;
  logic [3:0]        sub_cnt;
  logic [2:0]        bit_cnt;
  logic [1:0]        samp;
  logic              maj;
  logic              decide;
  logic              bit_end;
  logic              start_edge;
  logic [7:0]        shreg;
  logic              byte_valid;
`ifdef UART_RX_PARITY_EN
  logic              par_bad;
`endif

  // Synchroniser resets to the idle level so reset release never looks like a start edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q <= 2'b11;
      rx_d   <= 1'b1;
    end else begin
      sync_q <= {sync_q[0], rx};
      rx_d   <= rx_s;
    end
  end

  assign rx_s       = sync_q[1];
  assign start_edge = (state == ST_IDLE) && rx_d && !rx_s;

  // Restarting the divider on the start edge puts sub-tick 8 near mid-bit.
  always_ff @(posedge clk) begin
    if (rst || start_edge || tick) begin
      tick_cnt <= '0;
    end else begin
      tick_cnt <= tick_cnt + 1'b1;
    end
  end

  assign tick    = (tick_cnt == TICK_MAX);
  assign decide  = tick && (sub_cnt == 4'd9);
  assign bit_end = tick && (sub_cnt == 4'd15);
  assign maj     = (samp[0] & samp[1]) | (samp[0] & rx_s) | (samp[1] & rx_s);

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= ST_IDLE;
      sub_cnt    <= '0;
      bit_cnt    <= '0;
      samp       <= '0;
      shreg      <= '0;
      busy       <= 1'b0;
      frame_err  <= 1'b0;
      byte_valid <= 1'b0;
`ifdef UART_RX_PARITY_EN
      parity_err <= 1'b0;
      par_bad    <= 1'b0;
`endif
    end else begin
      frame_err  <= 1'b0;
      byte_valid <= 1'b0;
`ifdef UART_RX_PARITY_EN
      parity_err <= 1'b0;
`endif
      // NOTE: later non-blocking assignments in this block override these defaults.
      if (tick)                       sub_cnt <= sub_cnt + 4'd1;
      if (tick && sub_cnt == 4'd7)    samp[0] <= rx_s;
      if (tick && sub_cnt == 4'd8)    samp[1] <= rx_s;

      case (state)
        ST_IDLE: begin
          if (start_edge) begin
            state   <= ST_START;
            sub_cnt <= '0;
            bit_cnt <= '0;
            busy    <= 1'b1;
`ifdef UART_RX_PARITY_EN
            par_bad <= 1'b0;
`endif
          end
        end

        ST_START: begin
          if (decide && maj) begin
            state <= ST_IDLE;
            busy  <= 1'b0;
          end else if (bit_end) begin
            state <= ST_DATA;
          end
        end

        ST_DATA: begin
          if (decide) shreg <= {maj, shreg[7:1]};
          if (bit_end) begin
            if (bit_cnt == 3'd7) begin
`ifdef UART_RX_PARITY_EN
              state <= ST_PARITY;
`else
              state <= ST_STOP;
`endif
            end else begin
              bit_cnt <= bit_cnt + 3'd1;
            end
          end
        end

`ifdef UART_RX_PARITY_EN
        ST_PARITY: begin
          // Even parity: data plus parity bit must hold an even number of ones.
          if (decide && (^{shreg, maj})) begin
            parity_err <= 1'b1;
            par_bad    <= 1'b1;
          end
          if (bit_end) state <= ST_STOP;
        end
`endif

        ST_STOP: begin
          if (decide) begin
            if (maj) begin
`ifdef UART_RX_PARITY_EN
              byte_valid <= !par_bad;
`else
              byte_valid <= 1'b1;
`endif
              state <= ST_IDLE;
              busy  <= 1'b0;
            end else begin
              frame_err <= 1'b1;
              state     <= ST_WAIT_IDLE;
            end
          end
        end

        ST_WAIT_IDLE: begin
          if (rx_s) begin
            state <= ST_IDLE;
            busy  <= 1'b0;
          end
        end

        default: begin
          state <= ST_IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

  // Byte FIFO: pointers carry one extra wrap bit to tell full from empty.
  logic [7:0]  mem [FIFO_DEPTH];
  logic [AW:0] wr_ptr;
  logic [AW:0] rd_ptr;
  logic [AW:0] wr_next;
  logic [AW:0] rd_next;
  logic [7:0]  head_next;
  logic        full;
  logic        pop;
  logic        do_push;

  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign pop     = m_valid && m_ready;
  assign do_push = byte_valid && (!full || pop);

  always_comb begin
    rd_next   = rd_ptr + {{AW{1'b0}}, pop};
    wr_next   = wr_ptr + {{AW{1'b0}}, do_push};
    head_next = mem[rd_next[AW-1:0]];
    if (do_push && (rd_next == wr_ptr)) head_next = shreg;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      m_valid <= 1'b0;
      m_data  <= '0;
      overrun <= 1'b0;
    end else begin
      wr_ptr  <= wr_next;
      rd_ptr  <= rd_next;
      m_valid <= (wr_next != rd_next);
      if (wr_next != rd_next) m_data <= head_next;
      overrun <= byte_valid && full && !pop;
    end
  end

  // NOTE: storage is left unreset; the pointers alone define which entries are live.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= shreg;
  end

endmodule
